// File: rtl/ahb_decoder_dp_pkg.sv
// ---------------------------------------------------------------------------
// ahb_decoder_dp_pkg
// Shared AHB-Lite types for the decoder slice: transfer type, response type,
// the default-slave state encoding and the default address width.
// Optional feature macro used by this slice: AHB_DEC_REMAP_EN.
// ---------------------------------------------------------------------------
package ahb_decoder_dp_pkg;

  localparam int AHB_ADDR_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_type;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } hresp_type;

  // Explicit encodings keep the state register bit-compatible with the
  // older decoder that exposed it on a debug bus.
  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  // NONSEQ and SEQ are the only transfer types that carry real data.
  function automatic logic is_active(input htrans_type t);
    return (t == NONSEQ) || (t == SEQ);
  endfunction

endpackage

// File: rtl/ahb_decoder_dp_if.sv
// ---------------------------------------------------------------------------
// ahb_decoder_dp_if
// Bus bundle between the AHB layer and the decoder.
//   master modport : drives haddr/htrans/hready, observes decode results
//   slave  modport : the decoder side (ahb_decoder_dp)
// Signals: haddr, htrans, hready (address phase / global ready),
//          hsel, dp_sel, dp_def (selects), def_hready_out, def_hresp
//          (default-slave response).
// ---------------------------------------------------------------------------
interface ahb_decoder_dp_if
  import ahb_decoder_dp_pkg::*;
#(
  parameter int AHB_ADDR_WIDTH = AHB_ADDR_WIDTH_DEF,
  parameter int SLV_NUM        = 4
);
  logic [AHB_ADDR_WIDTH-1:0] haddr;
  htrans_type                htrans;
  logic                      hready;
  logic [SLV_NUM-1:0]        hsel;
  logic [SLV_NUM-1:0]        dp_sel;
  logic                      dp_def;
  logic                      def_hready_out;
  hresp_type                 def_hresp;

  modport master (
    output haddr, htrans, hready,
    input  hsel, dp_sel, dp_def, def_hready_out, def_hresp
  );

  modport slave (
    input  haddr, htrans, hready,
    output hsel, dp_sel, dp_def, def_hready_out, def_hresp
  );
endinterface

// File: rtl/ahb_default_slave.sv
// ---------------------------------------------------------------------------
// ahb_default_slave
// AHB default slave: answers unmapped NONSEQ/SEQ transfers with the
// two-cycle ERROR response and keeps a saturating decode-error counter.
// Ports:
//   hclk, hreset    clock, synchronous active-high reset
//   hready          global HREADY
//   acc_unmapped    an unmapped NONSEQ/SEQ address phase is being accepted
//   err_cnt_clr     synchronous clear of err_cnt (wins over increment)
//   hready_out      default-slave HREADYOUT
//   hresp           default-slave HRESP
//   err_cnt         saturating decode-error count
// ---------------------------------------------------------------------------
module ahb_default_slave
  import ahb_decoder_dp_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 hclk,
  input  logic                 hreset,
  input  logic                 hready,
  input  logic                 acc_unmapped,
  input  logic                 err_cnt_clr,
  output logic                 hready_out,
  output hresp_type            hresp,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  ds_state_t state, state_nxt;
  logic      go_err;
  logic      err_inc;

  assign go_err = hready && acc_unmapped;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      DS_IDLE: if (go_err) state_nxt = DS_ERR1;
      DS_ERR1: state_nxt = DS_ERR2;
      DS_ERR2: state_nxt = go_err ? DS_ERR1 : DS_IDLE;
      default: state_nxt = DS_IDLE;
    endcase
  end

  // Only entries into DS_ERR1 count; DS_ERR1 itself always leaves.
  assign err_inc = (state != DS_ERR1) && (state_nxt == DS_ERR1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state   <= DS_IDLE;
      err_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (err_cnt_clr)
        err_cnt <= '0;
      else if (err_inc && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
    end
  end

  // Moore outputs: stall only in the first ERROR cycle.
  assign hready_out = (state != DS_ERR1);
  assign hresp      = (state == DS_IDLE) ? OKAY : ERROR;

endmodule

// File: rtl/ahb_decoder_dp.sv
// ---------------------------------------------------------------------------
// ahb_decoder_dp
// AHB-Lite address decoder for one layer with SLV_NUM base/mask regions,
// a registered data-phase owner for the response mux, and the default slave.
// Ports:
//   hclk, hreset    clock, synchronous active-high reset
//   hremap          (only with AHB_DEC_REMAP_EN) swap regions of slaves 0/1
//   bus             ahb_decoder_dp_if.slave: haddr, htrans, hready in;
//                   hsel, dp_sel, dp_def, def_hready_out, def_hresp out
//   err_cnt_clr     synchronous clear of err_cnt
//   err_cnt         saturating decode-error count
// Optional feature macro: AHB_DEC_REMAP_EN (boot-ROM/RAM remap).
// ---------------------------------------------------------------------------
module ahb_decoder_dp
  import ahb_decoder_dp_pkg::*;
#(
  parameter int AHB_ADDR_WIDTH = AHB_ADDR_WIDTH_DEF,
  parameter int SLV_NUM        = 4,
  parameter logic [SLV_NUM-1:0][AHB_ADDR_WIDTH-1:0] SLV_BASE = '0,
  parameter logic [SLV_NUM-1:0][AHB_ADDR_WIDTH-1:0] SLV_MASK = '0,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                 hclk,
  input  logic                 hreset,
`ifdef AHB_DEC_REMAP_EN
  input  logic                 hremap,
`endif
  ahb_decoder_dp_if.slave      bus,
  input  logic                 err_cnt_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  if (SLV_NUM < 1 || SLV_NUM > 16) begin : g_bad_slv_num
    $error("ahb_decoder_dp: SLV_NUM must be 1..16");
  end
`ifdef AHB_DEC_REMAP_EN
  if (SLV_NUM < 2) begin : g_bad_remap
    $error("ahb_decoder_dp: AHB_DEC_REMAP_EN needs SLV_NUM >= 2");
  end
`endif

  logic [SLV_NUM-1:0][AHB_ADDR_WIDTH-1:0] eff_base;
  logic [SLV_NUM-1:0][AHB_ADDR_WIDTH-1:0] eff_mask;
  logic [SLV_NUM-1:0]                     hsel_c;
  logic                                   unmapped;
  logic                                   def_ap;
  logic                                   acc_unmapped;
  logic [SLV_NUM-1:0]                     dp_sel_q;
  logic                                   dp_def_q;

  // Region table after optional remap; priority is resolved afterwards so
  // the swapped pair keeps the index-based priority.
  always_comb begin
    eff_base = SLV_BASE;
    eff_mask = SLV_MASK;
`ifdef AHB_DEC_REMAP_EN
    if (hremap) begin
      eff_base[0] = SLV_BASE[1];
      eff_base[1] = SLV_BASE[0];
      eff_mask[0] = SLV_MASK[1];
      eff_mask[1] = SLV_MASK[0];
    end
`endif
  end

  // NOTE: blocking assignments here are intentional: 'found' must carry the
  // earlier iterations' result forward within the same evaluation.
  always_comb begin
    logic found;
    found  = 1'b0;
    hsel_c = '0;
    for (int i = 0; i < SLV_NUM; i++) begin
      if (!found &&
          ((bus.haddr & eff_mask[i]) == (eff_base[i] & eff_mask[i]))) begin
        hsel_c[i] = 1'b1;
        found     = 1'b1;
      end
    end
    unmapped = !found;
  end

  // IDLE and BUSY get the zero-wait OKAY from the default slave, whatever
  // region the address falls in.
  assign def_ap       = unmapped || !is_active(bus.htrans);
  assign acc_unmapped = bus.hready && unmapped && is_active(bus.htrans);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      dp_sel_q <= '0;
      dp_def_q <= 1'b1;
    end else if (bus.hready) begin
      dp_sel_q <= hsel_c;
      dp_def_q <= def_ap;
    end
  end

  assign bus.hsel   = hsel_c;
  assign bus.dp_sel = dp_sel_q;
  assign bus.dp_def = dp_def_q;

  ahb_default_slave #(
    .ERR_CNT_W (ERR_CNT_W)
  ) u_default_slave (
    .hclk         (hclk),
    .hreset       (hreset),
    .hready       (bus.hready),
    .acc_unmapped (acc_unmapped),
    .err_cnt_clr  (err_cnt_clr),
    .hready_out   (bus.def_hready_out),
    .hresp        (bus.def_hresp),
    .err_cnt      (err_cnt)
  );

endmodule

// File: tb/tb_ahb_decoder_dp.sv
// ---------------------------------------------------------------------------
// tb_ahb_decoder_dp
// Directed bench for ahb_decoder_dp with three slaves:
//   slave 0 0x0000_0000/0xFFFF_0000, slave 1 0x0001_0000/0xFFFF_0000,
//   slave 2 0x2000_0000/0xF000_0000.
// Remap scenario is compiled in only with AHB_DEC_REMAP_EN.
// ---------------------------------------------------------------------------
module tb_ahb_decoder_dp;
  import ahb_decoder_dp_pkg::*;

  localparam int AW = 32;
  localparam int NS = 3;
  localparam logic [NS-1:0][AW-1:0] BASE =
    {32'h2000_0000, 32'h0001_0000, 32'h0000_0000};
  localparam logic [NS-1:0][AW-1:0] MASK =
    {32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000};

  logic       hclk = 1'b0;
  logic       hreset;
  logic       err_cnt_clr;
  logic [7:0] err_cnt;
`ifdef AHB_DEC_REMAP_EN
  logic       hremap;
`endif

  int checks = 0;
  int errors = 0;

  ahb_decoder_dp_if #(.AHB_ADDR_WIDTH(AW), .SLV_NUM(NS)) bus ();

  ahb_decoder_dp #(
    .AHB_ADDR_WIDTH (AW),
    .SLV_NUM        (NS),
    .SLV_BASE       (BASE),
    .SLV_MASK       (MASK),
    .ERR_CNT_W      (8)
  ) dut (
    .hclk        (hclk),
    .hreset      (hreset),
`ifdef AHB_DEC_REMAP_EN
    .hremap      (hremap),
`endif
    .bus         (bus),
    .err_cnt_clr (err_cnt_clr),
    .err_cnt     (err_cnt)
  );

  always #5 hclk = ~hclk;

  // Advance one edge; inputs are changed and outputs sampled 1 ns later.
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic [AW-1:0] a, input htrans_type t, input logic rdy);
    bus.haddr  = a;
    bus.htrans = t;
    bus.hready = rdy;
    #1;
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    err_cnt_clr = 1'b0;
    drive(32'h4000_0000, IDLE, 1'b1);
    tick();
    tick();
    hreset = 1'b0;
    checks++; if (bus.dp_sel !== 3'b000) begin errors++; $display("FAIL reset_dp_sel: got %b expected %b", bus.dp_sel, 3'b000); end
    checks++; if (bus.dp_def !== 1'b1) begin errors++; $display("FAIL reset_dp_def: got %b expected 1", bus.dp_def); end
    checks++; if (bus.def_hready_out !== 1'b1) begin errors++; $display("FAIL reset_hready_out: got %b expected 1", bus.def_hready_out); end
    checks++; if (bus.def_hresp !== OKAY) begin errors++; $display("FAIL reset_hresp: got %b expected OKAY", bus.def_hresp); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_decode();
    drive(32'h0001_0004, NONSEQ, 1'b1);
    checks++; if (bus.hsel !== 3'b010) begin errors++; $display("FAIL ap_hsel_s1: got %b expected 010", bus.hsel); end
    tick();
    checks++; if (bus.dp_sel !== 3'b010) begin errors++; $display("FAIL dp_sel_s1: got %b expected 010", bus.dp_sel); end
    checks++; if (bus.dp_def !== 1'b0) begin errors++; $display("FAIL dp_def_s1: got %b expected 0", bus.dp_def); end
    drive(32'h2000_0000, NONSEQ, 1'b0);
    checks++; if (bus.hsel !== 3'b100) begin errors++; $display("FAIL ap_hsel_s2: got %b expected 100", bus.hsel); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.dp_sel !== 3'b010) begin errors++; $display("FAIL dp_sel_hold%0d: got %b expected 010", i, bus.dp_sel); end
    end
    drive(32'h0000_8000, IDLE, 1'b1);
    checks++; if (bus.hsel !== 3'b001) begin errors++; $display("FAIL ap_hsel_s0: got %b expected 001", bus.hsel); end
    tick();
    checks++; if (bus.dp_def !== 1'b1) begin errors++; $display("FAIL dp_def_idle: got %b expected 1", bus.dp_def); end
  endtask

  task automatic test_error();
    drive(32'h4000_0000, NONSEQ, 1'b1);
    checks++; if (bus.hsel !== 3'b000) begin errors++; $display("FAIL ap_hsel_unmapped: got %b expected 000", bus.hsel); end
    tick();
    checks++; if (bus.def_hready_out !== 1'b0) begin errors++; $display("FAIL err1_hready_out: got %b expected 0", bus.def_hready_out); end
    checks++; if (bus.def_hresp !== ERROR) begin errors++; $display("FAIL err1_hresp: got %b expected ERROR", bus.def_hresp); end
    checks++; if (bus.dp_def !== 1'b1) begin errors++; $display("FAIL err1_dp_def: got %b expected 1", bus.dp_def); end
    drive(32'h0000_0000, IDLE, 1'b0);
    tick();
    checks++; if (bus.def_hready_out !== 1'b1) begin errors++; $display("FAIL err2_hready_out: got %b expected 1", bus.def_hready_out); end
    checks++; if (bus.def_hresp !== ERROR) begin errors++; $display("FAIL err2_hresp: got %b expected ERROR", bus.def_hresp); end
    drive(32'h0000_0000, IDLE, 1'b1);
    tick();
    checks++; if (bus.def_hresp !== OKAY) begin errors++; $display("FAIL err_done_hresp: got %b expected OKAY", bus.def_hresp); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL err_cnt_one: got %0d expected 1", err_cnt); end
  endtask

  task automatic test_back_to_back();
    err_cnt_clr = 1'b1;
    tick();
    err_cnt_clr = 1'b0;
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL clr_err_cnt: got %0d expected 0", err_cnt); end
    drive(32'h4000_0000, NONSEQ, 1'b1);
    tick();
    checks++; if ({bus.def_hready_out, bus.def_hresp} !== {1'b0, ERROR}) begin errors++; $display("FAIL b2b_err1a: got %b/%b expected 0/1", bus.def_hready_out, bus.def_hresp); end
    drive(32'h0000_0000, IDLE, 1'b0);
    tick();
    checks++; if ({bus.def_hready_out, bus.def_hresp} !== {1'b1, ERROR}) begin errors++; $display("FAIL b2b_err2a: got %b/%b expected 1/1", bus.def_hready_out, bus.def_hresp); end
    drive(32'h5000_0000, NONSEQ, 1'b1);
    tick();
    checks++; if ({bus.def_hready_out, bus.def_hresp} !== {1'b0, ERROR}) begin errors++; $display("FAIL b2b_err1b: got %b/%b expected 0/1", bus.def_hready_out, bus.def_hresp); end
    drive(32'h0000_0000, IDLE, 1'b0);
    tick();
    checks++; if ({bus.def_hready_out, bus.def_hresp} !== {1'b1, ERROR}) begin errors++; $display("FAIL b2b_err2b: got %b/%b expected 1/1", bus.def_hready_out, bus.def_hresp); end
    drive(32'h0000_0000, IDLE, 1'b1);
    tick();
    checks++; if ({bus.def_hready_out, bus.def_hresp} !== {1'b1, OKAY}) begin errors++; $display("FAIL b2b_idle: got %b/%b expected 1/0", bus.def_hready_out, bus.def_hresp); end
    checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL b2b_err_cnt: got %0d expected 2", err_cnt); end
  endtask

  task automatic test_saturation();
    err_cnt_clr = 1'b1;
    tick();
    err_cnt_clr = 1'b0;
    // 255 back-to-back errors, two cycles each, ending in DS_ERR2.
    for (int i = 0; i < 255; i++) begin
      drive(32'h4000_0000, NONSEQ, 1'b1);
      tick();
      drive(32'h0000_0000, IDLE, 1'b0);
      tick();
    end
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_reach: got %0d expected 255", err_cnt); end
    drive(32'h4000_0000, NONSEQ, 1'b1);
    tick();
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d expected 255", err_cnt); end
    drive(32'h0000_0000, IDLE, 1'b0);
    tick();
    drive(32'h4000_0000, NONSEQ, 1'b1);
    err_cnt_clr = 1'b1;
    tick();
    err_cnt_clr = 1'b0;
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL clr_over_inc: got %0d expected 0", err_cnt); end
    checks++; if (bus.def_hready_out !== 1'b0) begin errors++; $display("FAIL clr_still_err1: got %b expected 0", bus.def_hready_out); end
    drive(32'h0000_0000, IDLE, 1'b0);
    tick();
    drive(32'h0000_0000, IDLE, 1'b1);
    tick();
  endtask

  task automatic test_mid_reset();
    drive(32'h4000_0000, NONSEQ, 1'b1);
    tick();
    hreset = 1'b1;
    drive(32'h0000_0000, IDLE, 1'b0);
    tick();
    hreset = 1'b0;
    checks++; if ({bus.def_hready_out, bus.def_hresp} !== {1'b1, OKAY}) begin errors++; $display("FAIL midrst_resp: got %b/%b expected 1/0", bus.def_hready_out, bus.def_hresp); end
    checks++; if ({bus.dp_sel, bus.dp_def} !== 4'b0001) begin errors++; $display("FAIL midrst_dp: got %b expected 0001", {bus.dp_sel, bus.dp_def}); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL midrst_err_cnt: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_idle_busy();
    drive(32'h4000_0000, IDLE, 1'b1);
    tick();
    checks++; if ({bus.dp_def, bus.def_hready_out, bus.def_hresp} !== {2'b11, OKAY}) begin errors++; $display("FAIL idle_unmapped: got %b expected 110", {bus.dp_def, bus.def_hready_out, bus.def_hresp}); end
    drive(32'h4000_0000, BUSY, 1'b1);
    tick();
    checks++; if ({bus.dp_def, bus.def_hready_out, bus.def_hresp} !== {2'b11, OKAY}) begin errors++; $display("FAIL busy_unmapped: got %b expected 110", {bus.dp_def, bus.def_hready_out, bus.def_hresp}); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL idle_busy_err_cnt: got %0d expected 0", err_cnt); end
  endtask

`ifdef AHB_DEC_REMAP_EN
  task automatic test_remap();
    hremap = 1'b1;
    drive(32'h0001_0000, NONSEQ, 1'b1);
    checks++; if (bus.hsel !== 3'b001) begin errors++; $display("FAIL remap_hsel_s0: got %b expected 001", bus.hsel); end
    drive(32'h0000_0010, NONSEQ, 1'b1);
    checks++; if (bus.hsel !== 3'b010) begin errors++; $display("FAIL remap_hsel_s1: got %b expected 010", bus.hsel); end
    tick();
    checks++; if (bus.dp_sel !== 3'b010) begin errors++; $display("FAIL remap_dp_sel: got %b expected 010", bus.dp_sel); end
    drive(32'h4000_0000, IDLE, 1'b1);
    tick();
    checks++; if ({bus.dp_def, bus.def_hresp} !== {1'b1, OKAY}) begin errors++; $display("FAIL remap_idle: got %b expected 10", {bus.dp_def, bus.def_hresp}); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL remap_err_cnt: got %0d expected 0", err_cnt); end
    hremap = 1'b0;
  endtask
`endif

  initial begin
`ifdef AHB_DEC_REMAP_EN
    hremap = 1'b0;
`endif
    test_reset();
    test_decode();
    test_error();
    test_back_to_back();
    test_saturation();
    test_mid_reset();
    test_idle_busy();
`ifdef AHB_DEC_REMAP_EN
    test_remap();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
